// File: rtl/cp0_regs.sv
// cp0_regs: MIPS CP0 register file with mtc0/mfc0 ports, Count/Compare
// timer and exception-driven Status/Cause/EPC/BadVAddr updates.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   we_i, waddr_i        mtc0 write enable and target register
//   data_i               mtc0 write data
//   raddr_i, data_o      mfc0 register select and combinational read data
//   int_i                level-sensitive hardware interrupts
//   excepttype_i         exception code from the M-stage decoder (0 = none)
//   current_inst_addr_i  PC of the M-stage instruction
//   is_in_delayslot_i    M-stage instruction sits in a delay slot
//   bad_addr_i           faulting address for AdEL/AdES
//   count_o .. badvaddr_o  registered CP0 state
//   timer_int_o          sticky Count==Compare interrupt
module cp0_regs #(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0] R_BADV = 5'd8;
    localparam logic [4:0] R_CNT  = 5'd9;
    localparam logic [4:0] R_CMP  = 5'd11;
    localparam logic [4:0] R_STAT = 5'd12;
    localparam logic [4:0] R_CAUS = 5'd13;
    localparam logic [4:0] R_EPC  = 5'd14;
    localparam logic [4:0] R_PRID = 5'd15;
    localparam logic [4:0] R_CFG  = 5'd16;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    logic tick;
    logic exc_valid;
    logic exc_int;
    logic exc_eret;
    logic exc_addr;
    logic wr_cnt;
    logic wr_cmp;
    logic [31:0] epc_next;

    // Only the listed codes are acted on; any other nonzero code is
    // treated as no exception so a pending mtc0 still lands.
    always_comb begin
        exc_valid = 1'b0;
        exc_int   = 1'b0;
        exc_eret  = 1'b0;
        exc_addr  = 1'b0;
        case (excepttype_i)
            32'h1: begin
                exc_valid = 1'b1;
                exc_int   = 1'b1;
            end
            32'h4, 32'h5: begin
                exc_valid = 1'b1;
                exc_addr  = 1'b1;
            end
            32'h8, 32'h9, 32'hA, 32'hC: begin
                exc_valid = 1'b1;
            end
            32'hE: begin
                exc_valid = 1'b1;
                exc_eret  = 1'b1;
            end
            default: begin
                exc_valid = 1'b0;
            end
        endcase
    end

    assign wr_cnt = we_i && (waddr_i == R_CNT);
    assign wr_cmp = we_i && (waddr_i == R_CMP);

    // A delay-slot fault restarts at the branch, one word earlier.
    assign epc_next = is_in_delayslot_i
                    ? current_inst_addr_i - 32'd4
                    : current_inst_addr_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick        <= 1'b0;
            count_o     <= '0;
            compare_o   <= '0;
            status_o    <= STATUS_RST;
            cause_o     <= '0;
            epc_o       <= '0;
            badvaddr_o  <= '0;
            timer_int_o <= 1'b0;
        end else begin
            tick <= ~tick;

            if (wr_cnt) begin
                count_o <= data_i;
            end else if (tick) begin
                count_o <= count_o + 32'd1;
            end

            if (wr_cmp) begin
                compare_o <= data_i;
            end

            // Compare write acknowledges the timer and beats a match.
            if (wr_cmp) begin
                timer_int_o <= 1'b0;
            end else if (compare_o != '0 &&
                         count_o == compare_o) begin
                timer_int_o <= 1'b1;
            end

            cause_o[15:10] <= {int_i[5] | timer_int_o,
                               int_i[4:0]};

            if (exc_valid) begin
                if (exc_eret) begin
                    status_o[1] <= 1'b0;
                end else begin
                    // Nested faults keep the original return point.
                    if (!status_o[1]) begin
                        epc_o      <= epc_next;
                        cause_o[31] <= is_in_delayslot_i;
                    end
                    status_o[1]  <= 1'b1;
                    cause_o[6:2] <= exc_int ? 5'd0
                                            : excepttype_i[4:0];
                    if (exc_addr) begin
                        badvaddr_o <= bad_addr_i;
                    end
                end
            end else if (we_i) begin
                case (waddr_i)
                    R_EPC: begin
                        epc_o <= data_i;
                    end
                    R_STAT: begin
                        status_o[15:8] <= data_i[15:8];
                        status_o[1:0]  <= data_i[1:0];
                    end
                    R_CAUS: begin
                        cause_o[9:8] <= data_i[9:8];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        data_o = '0;
        case (raddr_i)
            R_BADV:  data_o = badvaddr_o;
            R_CNT:   data_o = count_o;
            R_CMP:   data_o = compare_o;
            R_STAT:  data_o = status_o;
            R_CAUS:  data_o = cause_o;
            R_EPC:   data_o = epc_o;
            R_PRID:  data_o = PRID_VAL;
            R_CFG:   data_o = CONFIG_VAL;
            default: data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: scoreboard bench for cp0_regs; expectations are queued
// when stimulus is driven and compared after the following clock edge.
module tb_cp0_regs;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;

    cp0_regs dut (
        .clk                 (clk),
        .rst                 (rst),
        .we_i                (we_i),
        .waddr_i             (waddr_i),
        .raddr_i             (raddr_i),
        .data_i              (data_i),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .bad_addr_i          (bad_addr_i),
        .data_o              (data_o),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .badvaddr_o          (badvaddr_o),
        .timer_int_o         (timer_int_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // sel 0..31 reads data_o through raddr_i; higher values pick
    // a direct output port.
    localparam int S_CNT  = 32;
    localparam int S_CMP  = 33;
    localparam int S_STAT = 34;
    localparam int S_CAUS = 35;
    localparam int S_EPC  = 36;
    localparam int S_BADV = 37;
    localparam int S_TMR  = 38;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic expect_val(input string tag,
                              input int sel,
                              input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic observe(input int sel,
                           output logic [31:0] v);
        v = '0;
        if (sel < 32) begin
            raddr_i = sel[4:0];
            #1;
            v = data_o;
        end else begin
            case (sel)
                S_CNT:   v = count_o;
                S_CMP:   v = compare_o;
                S_STAT:  v = status_o;
                S_CAUS:  v = cause_o;
                S_EPC:   v = epc_o;
                S_BADV:  v = badvaddr_o;
                S_TMR:   v = {31'd0, timer_int_o};
                default: v = 'x;
            endcase
        end
    endtask

    task automatic step();
        exp_t e;
        logic [31:0] v;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            observe(e.sel, v);
            chk(e.tag, v, e.val);
        end
    endtask

    task automatic idle();
        we_i                = 1'b0;
        waddr_i             = '0;
        data_i              = '0;
        excepttype_i        = '0;
        current_inst_addr_i = '0;
        is_in_delayslot_i   = 1'b0;
        bad_addr_i          = '0;
    endtask

    task automatic wr(input logic [4:0] a,
                      input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = a;
        data_i  = d;
    endtask

    task automatic exc(input logic [31:0] t,
                       input logic [31:0] pc,
                       input logic ds);
        excepttype_i        = t;
        current_inst_addr_i = pc;
        is_in_delayslot_i   = ds;
    endtask

    initial begin
        rst     = 1'b1;
        int_i   = '0;
        raddr_i = '0;
        idle();

        expect_val("rst_r12", 12, 32'h0040_0000);
        expect_val("rst_r15", 15, 32'h0000_4220);
        expect_val("rst_r16", 16, 32'h0000_8000);
        expect_val("rst_cnt", S_CNT, 32'h0);
        expect_val("rst_cmp", S_CMP, 32'h0);
        expect_val("rst_cause", S_CAUS, 32'h0);
        expect_val("rst_epc", S_EPC, 32'h0);
        expect_val("rst_badv", S_BADV, 32'h0);
        expect_val("rst_tmr", S_TMR, 32'h0);
        expect_val("rst_r3", 3, 32'h0);
        step();
        rst = 1'b0;

        // Count wrap, one increment per two cycles
        wr(5'd9, 32'hFFFF_FFFE);
        expect_val("cnt_wr", S_CNT, 32'hFFFF_FFFE);
        step();
        idle();
        expect_val("cnt_a", S_CNT, 32'hFFFF_FFFF);
        step();
        expect_val("cnt_b", S_CNT, 32'hFFFF_FFFF);
        step();
        expect_val("cnt_wrap", S_CNT, 32'h0);
        step();
        expect_val("cnt_c", S_CNT, 32'h0);
        step();
        expect_val("cnt_d", 9, 32'h1);
        step();

        // Timer
        wr(5'd11, 32'h10);
        expect_val("cmp_wr", S_CMP, 32'h10);
        expect_val("tmr_lo0", S_TMR, 32'h0);
        step();
        idle();
        wr(5'd9, 32'h0C);
        expect_val("cnt_0c", S_CNT, 32'h0C);
        step();
        idle();
        repeat (7) step();
        expect_val("cnt_10", S_CNT, 32'h10);
        expect_val("tmr_lo1", S_TMR, 32'h0);
        step();
        expect_val("tmr_hi", S_TMR, 32'h1);
        expect_val("ip7_lag", S_CAUS, 32'h0);
        step();
        expect_val("tmr_hold", S_TMR, 32'h1);
        expect_val("ip7_set", 13, 32'h0000_8000);
        step();
        expect_val("tmr_hold2", S_TMR, 32'h1);
        step();
        wr(5'd11, 32'h0);
        expect_val("tmr_clr", S_TMR, 32'h0);
        expect_val("ip7_lag2", S_CAUS, 32'h0000_8000);
        step();
        idle();
        expect_val("ip7_clr", S_CAUS, 32'h0);
        expect_val("tmr_stay", S_TMR, 32'h0);
        step();

        // Syscall in delay slot, then nested overflow
        exc(32'h8, 32'hBFC0_0100, 1'b1);
        expect_val("sys_epc", S_EPC, 32'hBFC0_00FC);
        expect_val("sys_cause", S_CAUS, 32'h8000_0020);
        expect_val("sys_stat", S_STAT, 32'h0040_0002);
        step();
        exc(32'hC, 32'h0000_0200, 1'b0);
        expect_val("ov_epc", S_EPC, 32'hBFC0_00FC);
        expect_val("ov_cause", S_CAUS, 32'h8000_0030);
        expect_val("ov_stat", S_STAT, 32'h0040_0002);
        step();
        exc(32'hE, 32'h0, 1'b0);
        expect_val("eret1_st", S_STAT, 32'h0040_0000);
        expect_val("eret1_epc", S_EPC, 32'hBFC0_00FC);
        step();

        // AdEL colliding with mtc0 EPC
        exc(32'h4, 32'h0000_0400, 1'b0);
        bad_addr_i = 32'h8000_0003;
        wr(5'd14, 32'h0000_1234);
        expect_val("adel_badv", S_BADV, 32'h8000_0003);
        expect_val("adel_epc", S_EPC, 32'h0000_0400);
        expect_val("adel_cause", S_CAUS, 32'h0000_0010);
        expect_val("adel_stat", S_STAT, 32'h0040_0002);
        step();
        idle();
        exc(32'hE, 32'h0, 1'b0);
        expect_val("eret2_st", S_STAT, 32'h0040_0000);
        expect_val("eret2_r14", 14, 32'h0000_0400);
        expect_val("eret2_r8", 8, 32'h8000_0003);
        step();
        idle();
        exc(32'h3, 32'h0000_0700, 1'b1);
        expect_val("bad_code_st", S_STAT, 32'h0040_0000);
        expect_val("bad_code_ca", S_CAUS, 32'h0000_0010);
        expect_val("bad_code_epc", S_EPC, 32'h0000_0400);
        step();
        idle();

        // Reset overrides a simultaneous exception
        rst = 1'b1;
        exc(32'h8, 32'h0000_0800, 1'b1);
        expect_val("rx_stat", S_STAT, 32'h0040_0000);
        expect_val("rx_epc", S_EPC, 32'h0);
        expect_val("rx_cause", S_CAUS, 32'h0);
        expect_val("rx_badv", S_BADV, 32'h0);
        expect_val("rx_cnt", S_CNT, 32'h0);
        step();
        rst = 1'b0;
        idle();

        // Writable field masks
        wr(5'd12, 32'hFFFF_FFFF);
        expect_val("st_mask", S_STAT, 32'h0040_FF03);
        step();
        wr(5'd13, 32'hFFFF_FFFF);
        expect_val("ca_mask", S_CAUS, 32'h0000_0300);
        step();
        wr(5'd8, 32'h0000_DEAD);
        expect_val("badv_ro", S_BADV, 32'h0);
        step();
        idle();

        // Interrupt exception with EXL already set
        int_i = 6'b000101;
        exc(32'h1, 32'h0000_0500, 1'b0);
        expect_val("int_cause", S_CAUS, 32'h0000_1700);
        expect_val("int_epc", S_EPC, 32'h0);
        expect_val("int_stat", 12, 32'h0040_FF03);
        step();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
